// File: rtl/vga_timing.sv
// vga_timing: 1280x1024@60 raster generator with Life-engine step pacing.
// Optional feature macro: VGA_STEP_HANDSHAKE_EN
//   defined   -> step_req/step_ack FSM, frame_cnt and overrun detection
//   undefined -> step_req = run & frame_start, step_overrun = 0
module vga_timing #(
  parameter int unsigned H_ACTIVE    = 1280,
  parameter int unsigned H_FP        = 48,
  parameter int unsigned H_SYNC      = 112,
  parameter int unsigned H_BP        = 248,
  parameter int unsigned V_ACTIVE    = 1024,
  parameter int unsigned V_FP        = 1,
  parameter int unsigned V_SYNC      = 3,
  parameter int unsigned V_BP        = 38,
  parameter logic        SYNC_POL    = 1'b1,
  parameter int unsigned STEP_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        step_ack,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic        step_req,
  output logic        step_overrun
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_q, video_d;
  logic        frame_start_q, frame_start_d;
  logic        x_wrap, y_wrap, wrap_d;

  // Next counter position and the raster outputs that describe it
  always_comb begin
    x_wrap = (x_q == H_LAST);
    y_wrap = (y_q == V_LAST);
    x_d    = x_wrap ? 11'd0 : x_q + 11'd1;
    y_d    = y_q;
    if (x_wrap) begin
      y_d = y_wrap ? 11'd0 : y_q + 11'd1;
    end
    wrap_d        = x_wrap & y_wrap;
    hsync_d       = ((x_d >= HS_START) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((y_d >= VS_START) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    video_d       = (x_d < H_ACT) && (y_d < V_ACT);
    frame_start_d = wrap_d;
  end

  // Raster registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q           <= 11'd0;
      y_q           <= 11'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_q       <= video_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;
  assign frame_start = frame_start_q;

`ifdef VGA_STEP_HANDSHAKE_EN

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  localparam logic [7:0] SF_LAST = 8'(STEP_FRAMES - 1);

  state_t     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       overrun_q, overrun_d;
  logic       vblank_start_d;

  // Step FSM: request at vblank start every STEP_FRAMES frames; ack beats the wrap
  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    overrun_d      = 1'b0;
    vblank_start_d = (x_d == 11'd0) && (y_d == V_ACT);
    if (wrap_d) begin
      frame_cnt_d = (frame_cnt_q == SF_LAST) ? 8'd0 : frame_cnt_q + 8'd1;
    end
    case (state_q)
      IDLE: begin
        if (vblank_start_d && run && (frame_cnt_q == SF_LAST)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (step_ack) begin
          state_d = IDLE;
        end else if (wrap_d) begin
          state_d   = IDLE;
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Step FSM state, frame counter and overrun pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_cnt_q <= 8'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign step_req     = (state_q == REQ);
  assign step_overrun = overrun_q;

`else

  // Without the handshake the engine steps on every frame while running
  logic unused_step;
  assign unused_step  = ^{step_ack, 8'(STEP_FRAMES)};
  assign step_req     = run & frame_start_q;
  assign step_overrun = 1'b0;

`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks of raster timing and step pacing on a
// reduced raster (38 x 18, frame = 684 clocks), STEP_FRAMES = 2.
module tb_vga_timing;

  localparam int HT = 38;
  localparam int VT = 18;
  localparam int FR = HT * VT;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        step_ack;
  logic [10:0] x;
  logic [10:0] y;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        frame_start;
  logic        step_req;
  logic        step_overrun;

  int checks;
  int errors;
  int t_now;
  int ovr_cnt;

  vga_timing #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(8),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(3), .V_BP(4),
    .SYNC_POL(1'b1), .STEP_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step_ack(step_ack),
    .x(x), .y(y), .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .frame_start(frame_start), .step_req(step_req), .step_overrun(step_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int t;
    int ex;
    int ey;
    bit hs;
    bit vs;
    bit vid;
    bit fs;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0d expected %0d", name, t_now, got, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t_now++;
      ovr_cnt += int'(step_overrun);
    end
  endtask

  task automatic goto_t(input int target);
    adv(target - t_now);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n   = 1'b1;
    t_now   = 0;
    ovr_cnt = 0;
  endtask

  int mis_cnt;
  int fs_seen;
  int hs_seen;
  int vs_seen;
  int mx;
  int my;

  initial begin
    checks   = 0;
    errors   = 0;
    t_now    = 0;
    ovr_cnt  = 0;
    rst_n    = 1'b0;
    run      = 1'b0;
    step_ack = 1'b0;

    //             t                ex  ey  hs vs vid fs
    vecs[0]  = '{0,                  0,  0, 0, 0, 1, 0};
    vecs[1]  = '{19,                19,  0, 0, 0, 1, 0};
    vecs[2]  = '{20,                20,  0, 0, 0, 0, 0};
    vecs[3]  = '{23,                23,  0, 0, 0, 0, 0};
    vecs[4]  = '{24,                24,  0, 1, 0, 0, 0};
    vecs[5]  = '{29,                29,  0, 1, 0, 0, 0};
    vecs[6]  = '{30,                30,  0, 0, 0, 0, 0};
    vecs[7]  = '{37,                37,  0, 0, 0, 0, 0};
    vecs[8]  = '{38,                 0,  1, 0, 0, 1, 0};
    vecs[9]  = '{380,                0, 10, 0, 0, 0, 0};
    vecs[10] = '{418,                0, 11, 0, 1, 0, 0};
    vecs[11] = '{531,               37, 13, 0, 1, 0, 0};
    vecs[12] = '{532,                0, 14, 0, 0, 0, 0};
    vecs[13] = '{683,               37, 17, 0, 0, 0, 0};
    vecs[14] = '{684,                0,  0, 0, 0, 1, 1};
    vecs[15] = '{685,                1,  0, 0, 0, 1, 0};
    vecs[16] = '{684 + 418 + 25,    25, 11, 1, 1, 0, 0};

    do_reset();
    check("rst_step_req", step_req, 0);
    check("rst_step_overrun", step_overrun, 0);

    // Raster vectors from the first post-reset cycle
    for (int i = 0; i < 17; i++) begin
      goto_t(vecs[i].t);
      check("vec_x", x, vecs[i].ex);
      check("vec_y", y, vecs[i].ey);
      check("vec_hsync", hsync, vecs[i].hs);
      check("vec_vsync", vsync, vecs[i].vs);
      check("vec_video_on", video_on, vecs[i].vid);
      check("vec_frame_start", frame_start, vecs[i].fs);
    end

    // Two full frames compared against a position model
    mis_cnt = 0; fs_seen = 0; hs_seen = 0; vs_seen = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      adv(1);
      mx = t_now % HT;
      my = (t_now / HT) % VT;
      if (int'(x) != mx || int'(y) != my) mis_cnt++;
      if (hsync !== ((mx >= 24 && mx < 30) ? 1'b1 : 1'b0)) mis_cnt++;
      if (vsync !== ((my >= 11 && my < 14) ? 1'b1 : 1'b0)) mis_cnt++;
      if (video_on !== ((mx < 20 && my < 10) ? 1'b1 : 1'b0)) mis_cnt++;
      if (frame_start !== ((mx == 0 && my == 0) ? 1'b1 : 1'b0)) mis_cnt++;
      fs_seen += int'(frame_start);
      hs_seen += int'(hsync);
      vs_seen += int'(vsync);
    end
    check("frames_model_mismatches", mis_cnt, 0);
    check("frames_fs_count", fs_seen, 2);
    check("frames_hsync_cycles", hs_seen, 2 * VT * 6);
    check("frames_vsync_cycles", vs_seen, 2 * 3 * HT);

`ifdef VGA_STEP_HANDSHAKE_EN
    // Normal handshake: request in odd frames, ack 5 clocks later
    do_reset();
    run = 1'b1;
    goto_t(FR + 379);
    check("hs_req_before", step_req, 0);
    goto_t(FR + 380);
    check("hs_req_rise", step_req, 1);
    check("hs_req_x", x, 0);
    check("hs_req_y", y, 10);
    goto_t(FR + 385);
    step_ack = 1'b1;
    check("hs_req_held", step_req, 1);
    adv(1);
    step_ack = 1'b0;
    check("hs_req_fall", step_req, 0);
    goto_t(2 * FR + 380);
    check("hs_even_frame_no_req", step_req, 0);
    goto_t(3 * FR + 380);
    check("hs_req_frame3", step_req, 1);
    check("hs_no_overrun", ovr_cnt, 0);

    // No ack: held to the wrap, then a single-cycle overrun
    goto_t(4 * FR - 1);
    check("ovr_req_held", step_req, 1);
    adv(1);
    check("ovr_req_drop", step_req, 0);
    check("ovr_pulse", step_overrun, 1);
    adv(1);
    check("ovr_pulse_end", step_overrun, 0);
    check("ovr_count", ovr_cnt, 1);

    // Ack sampled at the wrap edge wins over the overrun
    goto_t(5 * FR + 380);
    check("wrapack_req", step_req, 1);
    goto_t(6 * FR - 1);
    step_ack = 1'b1;
    adv(1);
    step_ack = 1'b0;
    check("wrapack_req_drop", step_req, 0);
    check("wrapack_no_overrun", step_overrun, 0);

    // Ack already high at the entry edge gives a one-cycle request
    goto_t(7 * FR + 379);
    step_ack = 1'b1;
    adv(1);
    check("minw_req_rise", step_req, 1);
    adv(1);
    step_ack = 1'b0;
    check("minw_req_fall", step_req, 0);
    check("minw_ovr_count", ovr_cnt, 1);

    // run low: no request
    run = 1'b0;
    goto_t(9 * FR + 380);
    check("norun_no_req", step_req, 0);

    // Reset in the middle of a request
    run = 1'b1;
    goto_t(11 * FR + 380);
    check("rstreq_req", step_req, 1);
    goto_t(11 * FR + 386);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstreq_req_drop", step_req, 0);
    check("rstreq_no_overrun", step_overrun, 0);
    check("rstreq_x", x, 0);
    check("rstreq_y", y, 0);
    repeat (4) @(negedge clk);
    check("rstreq_held_overrun", step_overrun, 0);
    rst_n   = 1'b1;
    t_now   = 0;
    ovr_cnt = 0;
    check("rstreq_restart_x", x, 0);
    adv(1);
    check("rstreq_advance_x", x, 1);
    check("rstreq_advance_y", y, 0);
`else
    // Without the handshake: step_req follows run & frame_start
    do_reset();
    run = 1'b1;
    goto_t(FR - 1);
    check("nh_req_before", step_req, 0);
    adv(1);
    check("nh_req_at_fs", step_req, 1);
    check("nh_fs", frame_start, 1);
    adv(1);
    check("nh_req_after", step_req, 0);
    step_ack = 1'b1;
    goto_t(FR + 380);
    check("nh_no_vblank_req", step_req, 0);
    check("nh_ack_ignored_ovr", step_overrun, 0);
    run = 1'b0;
    goto_t(2 * FR);
    check("nh_fs_norun", frame_start, 1);
    check("nh_req_norun", step_req, 0);
    step_ack = 1'b0;
    check("nh_ovr_count", ovr_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates the 1280x1024@60 raster for the Life display. It drives the pixel coordinates `x`/`y` that the cell-colouring logic converts to `rgb`/`array_pos`, plus `hsync`, `vsync` and `video_on`. It also paces the Life engine: a `step_req`/`step_ack` handshake runs once every `STEP_FRAMES` frames, during vertical blanking, so that the `alive`/`alive_prev` arrays only change off-screen.

## Interface
- `H_ACTIVE`, 1280, visible pixels per line
- `H_FP`, 48, horizontal front porch (clocks)
- `H_SYNC`, 112, hsync width (clocks)
- `H_BP`, 248, horizontal back porch; line total 1688
- `V_ACTIVE`, 1024, visible lines
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 3, vsync width (lines)
- `V_BP`, 38, vertical back porch; frame total 1066
- `SYNC_POL`, 1'b1, active level of `hsync`/`vsync`
- `STEP_FRAMES`, 30, frames per generation step; legal range 1..255

Ports:
- `clk` input 1: pixel clock, 108 MHz
- `rst_n` input 1: synchronous reset, active-low
- `run` input 1: enables step requests; counters run regardless
- `step_ack` input 1: Life engine has finished a generation
- `x` output 11: horizontal counter, 0..H_total-1
- `y` output 11: vertical counter, 0..V_total-1
- `hsync` output 1: horizontal sync, level = `SYNC_POL` when active
- `vsync` output 1: vertical sync, level = `SYNC_POL` when active
- `video_on` output 1: high iff `x` < H_ACTIVE and `y` < V_ACTIVE
- `frame_start` output 1: one-cycle pulse at `x`=0, `y`=0
- `step_req` output 1: generation step request
- `step_overrun` output 1: one-cycle pulse when a request expires unacknowledged

## Operation
- Counter behaviour:
  - `x` increments every clock. It wraps H_total-1 -> 0.
  - `y` increments when `x` wraps. It wraps V_total-1 -> 0.
- `hsync` is active for `x` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 1328..1439.
- `vsync` is active for `y` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 1025..1027.
- `hsync`, `vsync`, `video_on` and `frame_start` are registered. Each is computed from the next counter value, so every output describes the same (`x`,`y`) in the same cycle.
- `frame_start` pulses when the counters wrap to (0,0). It does not pulse on the first cycle after reset.
- `frame_cnt` (8-bit) increments on each `frame_start`. It reaches STEP_FRAMES-1 and then wraps to 0.
- Step FSM, states IDLE and REQ:
  - IDLE -> REQ at the start of vertical blanking (`x`=0, `y`=V_ACTIVE) when `run`=1 and `frame_cnt`=STEP_FRAMES-1. `step_req` rises in that cycle.
  - REQ -> IDLE the cycle after `step_ack` is sampled high. `step_req` then drops.
  - REQ -> IDLE when the counters wrap to (0,0) without an ack. `step_overrun` pulses in that cycle.
  - `step_ack` wins when it is sampled high in the same cycle as the wrap: no overrun is reported.
  - `step_ack` is ignored in IDLE.
  - If `run` falls while in REQ, the request still completes normally.
- Arithmetic: counter compares use 11-bit unsigned values. Parameter sums must be ≤ 2047.

## Timing
- Reset values: `x`=0, `y`=0, `hsync`=`vsync`=~SYNC_POL, `video_on`=1, `frame_start`=0, `step_req`=0, `step_overrun`=0, `frame_cnt`=0, FSM=IDLE.
- The first clock with `rst_n`=1 presents (0,0). The counter advances on every subsequent edge.
- Reset asserted mid-REQ drops `step_req` on the next edge and does not pulse `step_overrun`.
- Minimum `step_req` width: 1 cycle, when ack is already high at the entry edge.
- Maximum `step_req` width: 42 lines × 1688 clocks = 70896 clocks.
- Line period: 1688 clocks. Frame period: 1799408 clocks.

## Configuration
- `VGA_STEP_HANDSHAKE_EN` defined: step FSM, `frame_cnt` and overrun detection are compiled in, as described above.
- `VGA_STEP_HANDSHAKE_EN` undefined:
  - The FSM and `frame_cnt` are removed.
  - `step_req` is `run & frame_start` (unconditional step every frame; `STEP_FRAMES` is ignored).
  - `step_overrun` is tied 0 and `step_ack` is ignored.
  - Raster outputs are identical in both builds.

## Test plan
- Reset: hold `rst_n`=0 for 5 clocks, then release -> all outputs at their reset values; first active cycle shows `x`=0, `y`=0, `video_on`=1.
- Line timing: run 2 lines ->
  - `hsync` active exactly for `x`=1328..1439;
  - `video_on` falls at `x`=1280;
  - `y` increments when `x` wraps 1687 -> 0.
- Frame timing: run 2 frames ->
  - `vsync` active for `y`=1025..1027;
  - `frame_start` pulses once per 1799408 clocks;
  - no `frame_start` pulse right after reset.
- Handshake: `STEP_FRAMES`=2, `run`=1, `step_ack` 5 clocks after `step_req` rises ->
  - `step_req` rises at `y`=1024, `x`=0 in every 2nd frame;
  - `step_req` falls the cycle after ack;
  - `step_overrun` never pulses.
- Overrun: `step_ack` held 0 -> `step_req` is held until (0,0), then drops; `step_overrun` is a 1-cycle pulse. Ack given at the wrap cycle -> no overrun.
- Run/reset: `run`=0 -> no requests. `rst_n` pulsed low mid-REQ -> `step_req`=0 the next cycle, no overrun, counters restart at (0,0).
